// File: rtl/led_blink_queue_pkg.sv
// led_blink_queue_pkg: shared types and constants for the LED blink queue.
// Holds the FSM state enum, width helpers and the default timing constants
// for the 25 MHz board clock.
package led_blink_queue_pkg;

    localparam int CLK_HZ             = 25_000_000;
    localparam int DEFAULT_ON_CYCLES  = CLK_HZ / 10;   // 100 ms
    localparam int DEFAULT_GAP_CYCLES = CLK_HZ / 20;   // 50 ms
    localparam int DEFAULT_QUEUE_MAX  = 15;
    localparam int DEFAULT_PWM_PERIOD = 16;
    localparam int DEFAULT_PWM_DUTY   = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } blink_state_e;

    // Bits needed to hold a pending count of 0..queue_max.
    function automatic int pend_width(input int queue_max);
        return $clog2(queue_max + 1);
    endfunction

    // Bits for a phase counter that runs 0..max(on,gap)-1; never below 1.
    function automatic int phase_width(input int on_cycles, input int gap_cycles);
        int longest;
        longest = (on_cycles > gap_cycles) ? on_cycles : gap_cycles;
        return (longest > 1) ? $clog2(longest) : 1;
    endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// led_pwm_gen: free-running PWM counter with duty compare, used to dim the
// LED during the ON phase. The level output reflects the counter value that
// will be live next cycle, so the caller can register it alongside the FSM.
module led_pwm_gen #(
    parameter int PWM_PERIOD = 16,
    parameter int PWM_DUTY   = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic advance_i,
    output logic level_o
);

    localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Restart on ON entry, wrap at the period end, hold when not advancing.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (advance_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign level_o = (int'(cnt_d) < PWM_DUTY);

endmodule

// File: rtl/led_blink_queue.sv
// led_blink_queue: turns single-cycle event pulses into fixed-length LED
// blinks (ON_CYCLES on, GAP_CYCLES forced off). Events arriving mid-blink are
// held in a saturating pending counter and replayed back-to-back.
// Build option: define LED_BLINK_PWM_EN to dim the ON phase through
// led_pwm_gen; without it o_LED is solid during ON and no PWM logic exists.
module led_blink_queue
    import led_blink_queue_pkg::*;
#(
    parameter int ON_CYCLES  = DEFAULT_ON_CYCLES,
    parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
    parameter int QUEUE_MAX  = DEFAULT_QUEUE_MAX,
    parameter int PWM_PERIOD = DEFAULT_PWM_PERIOD,
    parameter int PWM_DUTY   = DEFAULT_PWM_DUTY
) (
    input  logic                               i_Clk,
    input  logic                               i_Rst,
    input  logic                               i_Event,
    output logic                               o_LED,
    output logic                               o_Busy,
    output logic [pend_width(QUEUE_MAX)-1:0]   o_Pending,
    output logic                               o_Drop
);

    localparam int PEND_W  = pend_width(QUEUE_MAX);
    localparam int PHASE_W = phase_width(ON_CYCLES, GAP_CYCLES);

    localparam logic [PHASE_W-1:0] ON_LAST  = PHASE_W'(ON_CYCLES - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(QUEUE_MAX);

    if (ON_CYCLES < 1 || GAP_CYCLES < 1 || QUEUE_MAX < 1 ||
        PWM_PERIOD < 1 || PWM_DUTY < 0 || PWM_DUTY > PWM_PERIOD) begin : g_bad_params
        $error("led_blink_queue: illegal parameter combination");
    end

    blink_state_e        state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PEND_W-1:0]   pend_q, pend_d;
    logic                led_q, led_d;
    logic                busy_q, busy_d;
    logic                drop_q, drop_d;
    logic                on_done, gap_done, queue_full;
    logic                pwm_level;

    assign on_done    = (state_q == ST_ON)  && (phase_q == ON_LAST);
    assign gap_done   = (state_q == ST_GAP) && (phase_q == GAP_LAST);
    assign queue_full = (pend_q == PEND_MAX);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the same pre-edge values.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: a blink always runs ON then GAP; GAP ends into ON when
    // anything is queued, counting an event arriving on that very cycle.
    // NOTE: each combinational output is defaulted first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (i_Event)  state_d = ST_ON;
            ST_ON:   if (on_done)  state_d = ST_GAP;
            ST_GAP:  if (gap_done) state_d = ((pend_q != '0) || i_Event) ? ST_ON : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Phase and queue bookkeeping: phase restarts on every state entry;
    // the queue counts mid-blink events, saturating and flagging drops.
    always_comb begin
        phase_d = '0;
        pend_d  = pend_q;
        drop_d  = 1'b0;
        if ((state_d == state_q) && (state_q != ST_IDLE)) begin
            phase_d = phase_q + 1'b1;
        end
        if (state_q != ST_IDLE) begin
            if (gap_done && (state_d == ST_ON)) begin
                // Dequeue one; a same-cycle event takes the freed slot.
                if (!i_Event) begin
                    pend_d = pend_q - 1'b1;
                end
            end else if (i_Event) begin
                if (!queue_full) begin
                    pend_d = pend_q + 1'b1;
                end else begin
                    drop_d = 1'b1;
                end
            end
        end
    end

`ifdef LED_BLINK_PWM_EN
    logic pwm_clear, pwm_advance;

    assign pwm_clear   = (state_d == ST_ON) && (state_q != ST_ON);
    assign pwm_advance = (state_d == ST_ON) && (state_q == ST_ON);

    led_pwm_gen #(
        .PWM_PERIOD (PWM_PERIOD),
        .PWM_DUTY   (PWM_DUTY)
    ) u_pwm (
        .clk_i      (i_Clk),
        .rst_i      (i_Rst),
        .clear_i    (pwm_clear),
        .advance_i  (pwm_advance),
        .level_o    (pwm_level)
    );
`else
    assign pwm_level = 1'b1;
`endif

    // Output decode from the upcoming state so the pins register in step with it.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        led_d  = (state_d == ST_ON) && pwm_level;
    end

    // Datapath and output registers; reset aborts any blink and clears the queue.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            phase_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign o_LED     = led_q;
    assign o_Busy    = busy_q;
    assign o_Pending = pend_q;
    assign o_Drop    = drop_q;

endmodule
